// File: rtl/mem_port_ctrl.sv
// Load/store front end for a word-addressed ram: byte-addressed RV32I requests in,
// one registered ram access (or read-modify-write) per request, one response out.
module mem_port_ctrl #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_adr,
    output logic        ram_load,
    output logic [31:0] ram_in,
    input  logic [31:0] ram_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);

    logic [1:0]  state_reg;
    logic [1:0]  addr_lo_reg;
    logic [15:0] wdata_reg;
    logic [2:0]  funct3_reg;
    logic        we_reg;
    logic [31:0] ram_adr_reg;
    logic        ram_load_reg;
    logic [31:0] ram_in_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign ram_adr    = ram_adr_reg;
    assign ram_load   = ram_load_reg;
    assign ram_in     = ram_in_reg;

    // Legality of the request currently on the bus
    logic f3_bad;
    logic misaligned;
    logic out_of_range;
    logic req_illegal;

    always_comb begin
        f3_bad = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
            3'b100, 3'b101:         f3_bad = req_we;
            default:                f3_bad = 1'b1;
        endcase
        misaligned   = ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0]) ||
                       (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
        out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
        req_illegal  = f3_bad || misaligned || out_of_range;
    end

    // Load lane extraction with sign/zero extension (funct3[2] selects unsigned)
    logic [31:0] byte_shift;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_comb begin
        byte_shift = ram_out >> {addr_lo_reg, 3'b000};
        half_sel   = addr_lo_reg[1] ? ram_out[31:16] : ram_out[15:0];
        load_data  = ram_out;
        case (funct3_reg[1:0])
            2'b00:   load_data = {{24{byte_shift[7] & ~funct3_reg[2]}}, byte_shift[7:0]};
            2'b01:   load_data = {{16{half_sel[15] & ~funct3_reg[2]}}, half_sel};
            default: load_data = ram_out;
        endcase
    end

    // Sub-word store merge: replicate the new data across lanes, then pick per byte
    logic [31:0] rep_data;
    logic [3:0]  byte_en;
    logic [31:0] merged;

    always_comb begin
        if (funct3_reg[0]) begin
            rep_data = {2{wdata_reg}};
            byte_en  = addr_lo_reg[1] ? 4'b1100 : 4'b0011;
        end else begin
            rep_data = {4{wdata_reg[7:0]}};
            byte_en  = 4'b0001 << addr_lo_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = byte_en[gi] ? rep_data[8*gi +: 8] : ram_out[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_lo_reg    <= 2'b00;
            wdata_reg      <= 16'h0;
            funct3_reg     <= 3'b000;
            we_reg         <= 1'b0;
            ram_adr_reg    <= 32'h0;
            ram_load_reg   <= 1'b0;
            ram_in_reg     <= 32'h0;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo_reg <= req_addr[1:0];
                        wdata_reg   <= req_wdata[15:0];
                        funct3_reg  <= req_funct3;
                        we_reg      <= req_we;
                        if (req_illegal) begin
                            resp_rdata_reg <= 32'h0;
                            resp_err_reg   <= 1'b1;
                            state_reg      <= RESP;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            ram_adr_reg  <= {2'b00, req_addr[31:2]};
                            ram_in_reg   <= req_wdata;
                            ram_load_reg <= 1'b1;
                            state_reg    <= WR;
                        end else begin
                            ram_adr_reg <= {2'b00, req_addr[31:2]};
                            state_reg   <= RD;
                        end
                    end
                end
                RD: begin
                    if (we_reg) begin
                        ram_in_reg   <= merged;
                        ram_load_reg <= 1'b1;
                        state_reg    <= WR;
                    end else begin
                        resp_rdata_reg <= load_data;
                        resp_err_reg   <= 1'b0;
                        state_reg      <= RESP;
                    end
                end
                WR: begin
                    ram_load_reg   <= 1'b0;
                    resp_rdata_reg <= 32'h0;
                    resp_err_reg   <= 1'b0;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_rdata_reg <= 32'h0;
                        resp_err_reg   <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
